// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer: operand width,
// mult/div opcodes, borrowed alu opcodes and sequencer state encoding.
package muldiv_seq_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ALUOP_W = 5;

  localparam logic [1:0] MDOP_MULTU = 2'b00;
  localparam logic [1:0] MDOP_MULT  = 2'b01;
  localparam logic [1:0] MDOP_DIVU  = 2'b10;
  localparam logic [1:0] MDOP_DIV   = 2'b11;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 5'd1;

  typedef enum logic [2:0] {
    MD_IDLE  = 3'd0,
    MD_LOAD  = 3'd1,
    MD_ITER  = 3'd2,
    MD_FIXUP = 3'd3,
    MD_DONE  = 3'd4
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_negate.sv
// Conditional two's-complement negate of a WIDTH-bit value.
module muldiv_seq_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = en_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO and borrowing the shared alu.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes early once the remaining multiplier is zero.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mdop,
  input  logic [XLEN-1:0]    rs_val,
  input  logic [XLEN-1:0]    rt_val,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    hi,
  output logic [XLEN-1:0]    lo,
  output logic               alu_req,
  input  logic               alu_gnt,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [XLEN-1:0]    alu_result
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam int unsigned SH_W  = CNT_W + 1;
  localparam int unsigned PW    = 2 * XLEN;

  md_state_e          state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [XLEN-1:0]    acc_q, acc_d;    // multiply accumulator / divide remainder
  logic [XLEN-1:0]    mpl_q, mpl_d;    // multiplier+product low / quotient
  logic [XLEN-1:0]    opb_q, opb_d;    // multiplicand / divisor
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic               busy_q, busy_d, done_q, done_d, alu_req_q, alu_req_d;

  logic               neg_a_en, neg_b_en;
  logic [XLEN-1:0]    neg_b_in, neg_a_res, neg_b_res;
  logic [PW-1:0]      neg_p_res;

  logic [XLEN-1:0]    mul_sum;
  logic               mul_carry, mul_early;
  logic [PW:0]        mul_cat;
  logic [PW-1:0]      mul_shifted;
  logic [SH_W-1:0]    mul_shamt;
  logic [XLEN-1:0]    rem_sh;
  logic               div_ge, iter_last;

  muldiv_seq_negate #(.WIDTH(XLEN)) u_neg_a (
    .en_i  (neg_a_en),
    .val_i (mpl_q),
    .res_o (neg_a_res)
  );

  muldiv_seq_negate #(.WIDTH(XLEN)) u_neg_b (
    .en_i  (neg_b_en),
    .val_i (neg_b_in),
    .res_o (neg_b_res)
  );

  muldiv_seq_negate #(.WIDTH(PW)) u_neg_p (
    .en_i  (negq_q),
    .val_i ({acc_q, mpl_q}),
    .res_o (neg_p_res)
  );

  // Per-iteration datapath; the alu operands were registered from these same values.
  always_comb begin
    mul_sum   = mpl_q[0] ? alu_result : acc_q;
    mul_carry = mpl_q[0] & (alu_result < acc_q);
    mul_cat   = {mul_carry, mul_sum, mpl_q};
`ifdef MULDIV_EARLY_OUT_EN
    mul_early = ((mpl_q & ({XLEN{1'b1}} >> cnt_q) & ~XLEN'(1)) == '0);
    mul_shamt = mul_early ? (SH_W'(ITER) - SH_W'(cnt_q)) : SH_W'(1);
`else
    mul_early = 1'b0;
    mul_shamt = SH_W'(1);
`endif
    mul_shifted = PW'(mul_cat >> mul_shamt);
    rem_sh      = {acc_q[XLEN-2:0], mpl_q[XLEN-1]};
    div_ge      = acc_q[XLEN-1] | ~(rem_sh < opb_q);
    iter_last   = (cnt_q == CNT_W'(ITER - 1));
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mpl_d    = mpl_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_a_en = 1'b0;
    neg_b_en = 1'b0;
    neg_b_in = opb_q;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_LOAD;
          op_d    = mdop;
          mpl_d   = rs_val;
          opb_d   = rt_val;
        end
      end
      MD_LOAD: begin
        neg_a_en = op_q[0] & mpl_q[XLEN-1];
        neg_b_en = op_q[0] & opb_q[XLEN-1];
        negq_d   = op_q[0] & (mpl_q[XLEN-1] ^ opb_q[XLEN-1]);
        negr_d   = op_q[0] & mpl_q[XLEN-1];
        acc_d    = '0;
        cnt_d    = '0;
        if (op_q[1] && (opb_q == '0)) begin
          hi_d    = mpl_q;
          lo_d    = '1;
          state_d = MD_DONE;
        end else if (op_q[1]) begin
          mpl_d   = neg_a_res;
          opb_d   = neg_b_res;
          state_d = MD_ITER;
        end else begin
          opb_d   = neg_a_res;
          mpl_d   = neg_b_res;
          state_d = MD_ITER;
        end
      end
      MD_ITER: begin
        if (alu_gnt) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[1]) begin
            acc_d = div_ge ? alu_result : rem_sh;
            mpl_d = {mpl_q[XLEN-2:0], div_ge};
            if (iter_last) state_d = MD_FIXUP;
          end else begin
            {acc_d, mpl_d} = mul_shifted;
            if (iter_last || mul_early) state_d = MD_FIXUP;
          end
        end
      end
      MD_FIXUP: begin
        if (op_q[1]) begin
          neg_a_en = negq_q;
          neg_b_en = negr_q;
          neg_b_in = acc_q;
          lo_d     = neg_a_res;
          hi_d     = neg_b_res;
        end else begin
          {hi_d, lo_d} = neg_p_res;
        end
        state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase

    // Outputs are registered from next state so the alu sees this iteration's operands.
    busy_d    = (state_d == MD_LOAD) || (state_d == MD_ITER) || (state_d == MD_FIXUP);
    done_d    = (state_d == MD_DONE);
    alu_req_d = (state_d == MD_ITER);
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_op_d  = ALUOP_ADD;
    if (state_d == MD_ITER) begin
      alu_b_d = opb_d;
      if (op_d[1]) begin
        alu_a_d  = {acc_d[XLEN-2:0], mpl_d[XLEN-1]};
        alu_op_d = ALUOP_SUB;
      end else begin
        alu_a_d  = acc_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      mpl_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_req_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= ALUOP_ADD;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      mpl_q     <= mpl_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alu_req_q <= alu_req_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign alu_req = alu_req_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative MULT/MULTU/DIV/DIVU sequencer for the multicycle CPU.
- Owns the HI/LO registers and borrows the shared alu for its per-iteration add/subtract.
- Requests the alu through an alu_req/alu_gnt handshake; the main control FSM arbitrates and keeps priority.
- Started by the control FSM on a mult/div instruction; the FSM stalls on busy.

Parameters:
- ITER, 32, number of shift iterations (operand width; fixed at 32 for this datapath).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle launch pulse, sampled only in IDLE
- mdop  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse; hi/lo valid from this cycle
- hi  out  32  HI register
- lo  out  32  LO register
- alu_req  out  1  sequencer needs the alu this cycle
- alu_gnt  in  1  alu mux granted to sequencer this cycle
- alu_a  out  32  alu operand A
- alu_b  out  32  alu operand B
- alu_op  out  5  ALUOP_ADD or ALUOP_SUB
- alu_result  in  32  alu result, combinational, same cycle

Behaviour:
- Reset: state=IDLE; busy, done, alu_req = 0; hi, lo, alu_a, alu_b = 0; alu_op = ALUOP_ADD.
- States: IDLE -> LOAD -> ITER -> FIXUP -> DONE -> IDLE.
- IDLE: start=1 latches mdop, rs_val, rt_val and goes to LOAD. start in any other state is ignored.
- LOAD:
  - Signed ops (MULT, DIV) replace operands by their magnitudes using a local negator, not the alu.
  - Record neg_q = sign(rs) ^ sign(rt) and neg_r = sign(rs).
  - Clear accumulator and counter.
  - Divide with rt_val == 0: skip to DONE with hi = rs_val (raw), lo = 0xFFFFFFFF; no alu use.
- ITER: alu_req = 1. A cycle with alu_gnt = 0 is a stall: no register or counter changes.
- Multiply (granted cycle):
  - alu_a = acc, alu_b = mcand, alu_op = ADD.
  - If mplier[0] = 1: sum = alu_result and carry = (alu_result < acc), local unsigned compare. Otherwise sum = acc and carry = 0.
  - Shift {carry, sum, mplier} right by 1: acc gets the upper 32 bits, mplier the lower 32.
- Divide (granted cycle):
  - {sh, rem_sh, quo} = {rem, quo} << 1.
  - alu_a = rem_sh, alu_b = divisor, alu_op = SUB.
  - ge = sh | ~(rem_sh < divisor).
  - rem = ge ? alu_result : rem_sh; quo[0] = ge.
- Counter increments per granted cycle; after ITER granted cycles go to FIXUP.
- FIXUP:
  - Multiply: {hi, lo} = neg_q ? -{acc, mplier} : {acc, mplier}.
  - Divide: lo = neg_q ? -quo : quo; hi = neg_r ? -rem : rem.
  - Negation is local, 64-bit for multiply. alu_req = 0.
- DONE: done = 1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- Latency with continuous grant: done is high in the 35th cycle after the start edge (LOAD 1, ITER 32, FIXUP 1, DONE 1). Each denied cycle adds one.
- Divide-by-zero: done is high on the 2nd cycle after start.
- 0x80000000 / 0xFFFFFFFF (DIV): lo = 0x80000000, hi = 0. No trap.
- hi/lo hold their previous values until FIXUP; they stay readable while busy.
- Reset asserted mid-operation aborts the operation; all registers return to reset values.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a multiply with remaining multiplier == 0 at the start of a granted ITER cycle completes the shift directly in one cycle.
  - acc and mplier are right-shifted by the remaining count, then go to FIXUP.
  - Multiplier 0 or 1 finishes in ≤4 cycles.
  - Division is unchanged.
- Undefined: every multiply takes ITER granted cycles; logic for the feature is absent.

Decomposition:
- Add MDOP_MULTU/MULT/DIVU/DIV (2-bit) and the state encodings to the shared ctrl_def.v.
- Reuse ALUOP_ADD / ALUOP_SUB from ctrl_def.v.
- One sub-module is natural: muldiv_negate, a parameterised-width conditional two's-complement negate. It is instantiated for the LOAD magnitudes and the FIXUP sign correction.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, gnt=1 constant -> done at cycle 35, hi=0xFFFFFFFE, lo=0x00000001.
- MULT −7 × 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; repeat with alu_gnt toggling every other cycle -> same values, done at cycle 67.
- DIV −17 / 5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE; DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5 / 0 -> done cycle 2, hi=5, lo=0xFFFFFFFF, alu_req never high.
- start pulsed while busy -> ignored, original result intact; rst_n low at ITER cycle 10 -> all outputs 0 next edge, new start runs cleanly.
- With MULDIV_EARLY_OUT_EN: MULTU 0x1234 × 1 -> hi=0, lo=0x1234, done within 4 cycles. Without the macro -> done at cycle 35.
